// File: rtl/pipelined_register_chain_pkg.sv
// Shared constants for the pipelined register chain.
//
// Contents:
//   BITS           default data width used by benchmark top-levels (32)
//   DEFAULT_STAGES default number of register stages (2)
//   occ_width()    width of a counter that can hold 0..stages inclusive
package pipelined_register_chain_pkg;

    localparam int BITS           = 32;
    localparam int DEFAULT_STAGES = 2;

    function automatic int occ_width(input int stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/pipelined_register_chain_pipe_stage.sv
// One valid/data register of the pipelined register chain.
//
// Parameters:
//   WIDTH     data width in bits
// Ports:
//   clk       clock, state updates on posedge
//   rst_n     asynchronous active-low reset (clears valid and data)
//   up_valid  upstream has a word on up_data
//   up_data   upstream word
//   dn_ready  downstream can take this stage's word this cycle
//   flush     synchronous discard of the held word
//   valid_q   this stage holds a valid word
//   data_q    word held by this stage
//   up_ready  this stage can load from upstream this cycle
module pipe_stage
    import pipelined_register_chain_pkg::*;
#(
    parameter int WIDTH = BITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             dn_ready,
    input  logic             flush,
    output logic             valid_q,
    output logic [WIDTH-1:0] data_q,
    output logic             up_ready
);

    // An empty stage always accepts, even while downstream is stalled,
    // so bubbles collapse instead of propagating.
    assign up_ready = !valid_q || dn_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (flush) begin
            // Flush wins over any load; the data register is left as-is.
            valid_q <= 1'b0;
        end else if (up_ready) begin
            valid_q <= up_valid;
            if (up_valid) begin
                data_q <= up_data;
            end
        end
    end

endmodule

// File: rtl/pipelined_register_chain.sv
// Retiming chain of STAGES valid/ready register stages with back-pressure,
// synchronous flush and an occupancy count. Full throughput of one word per
// cycle while out_ready stays high; latency is STAGES cycles.
//
// Parameters:
//   WIDTH      data width in bits (>= 1)
//   STAGES     number of register stages (>= 1)
//   OCC_W      derived occupancy width, $clog2(STAGES+1)
// Ports:
//   clk        clock, all state updates on posedge
//   rst_n      asynchronous active-low reset
//   in_valid   producer has a word on in_data
//   in_ready   chain accepts in_data this cycle
//   in_data    input word
//   out_valid  out_data holds a valid word
//   out_ready  consumer takes out_data this cycle
//   out_data   output word (last stage register)
//   flush      synchronous discard of every word in flight
//   occupancy  number of stages currently holding a valid word
module pipelined_register_chain
    import pipelined_register_chain_pkg::*;
#(
    parameter int  WIDTH  = BITS,
    parameter int  STAGES = DEFAULT_STAGES,
    localparam int OCC_W  = occ_width(STAGES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [OCC_W-1:0] occupancy
);

    logic [STAGES-1:0] valid_q;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [OCC_W-1:0]  occ_sum;

    // Each stage keeps its own ready wires so the output-to-input ready
    // chain runs through distinct signals rather than bits of one vector.
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic             up_valid;
        logic [WIDTH-1:0] up_data;
        logic             up_ready;
        logic             dn_ready;

        if (i == 0) begin : g_head
            assign up_valid = in_valid;
            assign up_data  = in_data;
        end else begin : g_body
            assign up_valid = valid_q[i-1];
            assign up_data  = data_q[i-1];
        end

        if (i == STAGES - 1) begin : g_tail
            assign dn_ready = out_ready;
        end else begin : g_link
            assign dn_ready = g_stage[i+1].up_ready;
        end

        pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .up_valid (up_valid),
            .up_data  (up_data),
            .dn_ready (dn_ready),
            .flush    (flush),
            .valid_q  (valid_q[i]),
            .data_q   (data_q[i]),
            .up_ready (up_ready)
        );
    end

    // No flush term here: a word offered during flush sees the normal
    // ready and is simply discarded by the stage.
    assign in_ready = g_stage[0].up_ready;

    assign out_valid = valid_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];

    always_comb begin
        occ_sum = '0;
        for (int i = 0; i < STAGES; i++) begin
            occ_sum = occ_sum + OCC_W'(valid_q[i]);
        end
    end

    assign occupancy = occ_sum;

endmodule

// File: tb/tb_pipelined_register_chain.sv
module tb_pipelined_register_chain;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic        flush;
    logic [31:0] in_data;

    logic        a_in_ready, a_out_valid;
    logic [31:0] a_out_data;
    logic [1:0]  a_occ;
    logic        b_in_ready, b_out_valid;
    logic [31:0] b_out_data;
    logic [1:0]  b_occ;
    logic        c_in_ready, c_out_valid;
    logic [0:0]  c_out_data;
    logic [0:0]  c_occ;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipelined_register_chain #(.WIDTH(32), .STAGES(2)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_data(a_out_data), .flush(flush), .occupancy(a_occ));

    pipelined_register_chain #(.WIDTH(32), .STAGES(3)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_data(b_out_data), .flush(flush), .occupancy(b_occ));

    pipelined_register_chain #(.WIDTH(1), .STAGES(1)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_data(in_data[0:0]), .out_valid(c_out_valid), .out_ready(out_ready),
        .out_data(c_out_data), .flush(flush), .occupancy(c_occ));

    // Reference model: each chain is a row of slots; words are tokens that
    // leave from the last slot when the consumer is ready and otherwise
    // slide forward one slot whenever the slot ahead is (or becomes) free.
    int          nst [3] = '{2, 3, 1};
    string       nm  [3] = '{"A", "B", "C"};
    logic [31:0] msk [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    bit          full [3][3];
    logic [31:0] sd   [3][3];

    function automatic int count_words(input int d);
        int c = 0;
        for (int p = 0; p < nst[d]; p++) c += full[d][p] ? 1 : 0;
        return c;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 3; d++)
            for (int p = 0; p < 3; p++) full[d][p] = 1'b0;
    endtask

    task automatic model_edge(input int d);
        int n = nst[d];
        bit room = (count_words(d) < n) || out_ready;
        if (flush) begin
            for (int p = 0; p < n; p++) full[d][p] = 1'b0;
        end else begin
            if (out_ready && full[d][n-1]) full[d][n-1] = 1'b0;
            for (int p = n - 2; p >= 0; p--) begin
                if (full[d][p] && !full[d][p+1]) begin
                    full[d][p+1] = 1'b1;
                    sd[d][p+1]   = sd[d][p];
                    full[d][p]   = 1'b0;
                end
            end
            if (in_valid && room) begin
                full[d][0] = 1'b1;
                sd[d][0]   = in_data;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input int d, input logic ov, input logic [31:0] od,
                             input logic [31:0] occ, input logic ir);
        int n   = nst[d];
        int cnt = count_words(d);
        chk({nm[d], ".out_valid"}, {31'b0, ov}, {31'b0, full[d][n-1]});
        chk({nm[d], ".occupancy"}, occ, 32'(cnt));
        chk({nm[d], ".in_ready"}, {31'b0, ir}, {31'b0, (cnt < n) || out_ready});
        if (full[d][n-1]) chk({nm[d], ".out_data"}, od & msk[d], sd[d][n-1] & msk[d]);
    endtask

    // One clock: compare against the model mid-cycle, then advance the model
    // at the edge; returns 1 time unit after the edge so inputs can change.
    task automatic step();
        @(negedge clk);
        check_dut(0, a_out_valid, a_out_data, 32'(a_occ), a_in_ready);
        check_dut(1, b_out_valid, b_out_data, 32'(b_occ), b_in_ready);
        check_dut(2, c_out_valid, {31'b0, c_out_data}, 32'(c_occ), c_in_ready);
        @(posedge clk);
        if (rst_n) for (int d = 0; d < 3; d++) model_edge(d);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_data = '0;
        model_clear();
        #1;
        chk("reset.out_valid", {31'b0, a_out_valid}, 32'd0);
        chk("reset.out_data", a_out_data, 32'd0);
        chk("reset.occupancy", 32'(a_occ), 32'd0);
        chk("reset.in_ready", {31'b0, a_in_ready}, 32'd1);
        step();
        step();
        rst_n = 1'b1;

        // Streaming: consecutive words emerge on consecutive cycles.
        out_ready = 1'b1; in_valid = 1'b1;
        in_data = 32'h1; step();
        in_data = 32'h2; step();
        chk("stream.w1", a_out_data, 32'h1);
        in_data = 32'h3; step();
        chk("stream.w2", a_out_data, 32'h2);
        in_valid = 1'b0; step();
        chk("stream.w3", a_out_data, 32'h3);
        chk("stream.valid", {31'b0, a_out_valid}, 32'd1);
        step();
        chk("stream.drained", {31'b0, a_out_valid}, 32'd0);
        step(); step(); step();

        // Back-pressure.
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 32'hAAAA_0001; step();
        in_data = 32'hAAAA_0002; step();
        in_data = 32'hAAAA_0003; #1;
        chk("bp.occupancy", 32'(a_occ), 32'd2);
        chk("bp.in_ready", {31'b0, a_in_ready}, 32'd0);
        chk("bp.out_data", a_out_data, 32'hAAAA_0001);
        step();
        chk("bp.hold_data", a_out_data, 32'hAAAA_0001);
        out_ready = 1'b1; step();
        out_ready = 1'b0; #1;
        chk("bp.release_occ", 32'(a_occ), 32'd2);
        chk("bp.release_data", a_out_data, 32'hAAAA_0002);

        // Flush with a simultaneous offered word.
        flush = 1'b1; in_valid = 1'b1; in_data = 32'h55; step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush.occupancy", 32'(a_occ), 32'd0);
        chk("flush.out_valid", {31'b0, a_out_valid}, 32'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("flush.no_55", {31'b0, a_out_valid}, 32'd0);
        end

        // Bubble collapse on the 3-stage chain.
        in_valid = 1'b1; in_data = 32'h77; step();
        in_valid = 1'b0; step(); step();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h88; #1;
        chk("bubble.occ1", 32'(b_occ), 32'd1);
        chk("bubble.in_ready", {31'b0, b_in_ready}, 32'd1);
        step();
        in_data = 32'h99; step();
        chk("bubble.occ3", 32'(b_occ), 32'd3);
        chk("bubble.full_ready", {31'b0, b_in_ready}, 32'd0);

        // WIDTH=1, STAGES=1 alternating bits at full rate.
        in_valid = 1'b0; out_ready = 1'b1;
        step(); step(); step();
        in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_data = 32'(k % 2);
            step();
            chk("w1.data", {31'b0, c_out_data}, 32'(k % 2));
            chk("w1.occ", 32'(c_occ), 32'd1);
        end

        // Randomised traffic.
        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            flush     = ($urandom_range(19) == 0);
            in_data   = $urandom;
            step();
        end
        flush = 1'b0;

        // Asynchronous reset with words in flight.
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 32'hDEAD_0001; step();
        in_data = 32'hDEAD_0002; step();
        chk("rst.preocc", 32'(a_occ), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        chk("rst.out_valid", {31'b0, a_out_valid}, 32'd0);
        chk("rst.out_data", a_out_data, 32'd0);
        chk("rst.occupancy", 32'(a_occ), 32'd0);
        chk("rst.in_ready", {31'b0, a_in_ready}, 32'd1);
        chk("rst.b_occ", 32'(b_occ), 32'd0);
        chk("rst.c_valid", {31'b0, c_out_valid}, 32'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        in_data = 32'h0000_BEEF; step();
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
